// File: rtl/hack_dbg_pkg.sv
// Shared definitions for the Hack CPU debug/run controller.
package hack_dbg_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_HALT      = 3'd1;
    localparam logic [2:0] OP_RUN       = 3'd2;
    localparam logic [2:0] OP_STEP      = 3'd3;
    localparam logic [2:0] OP_RESET_CPU = 3'd4;
    localparam logic [2:0] OP_SET_BP    = 3'd5;
    localparam logic [2:0] OP_MEM_RD    = 3'd6;
    localparam logic [2:0] OP_MEM_WR    = 3'd7;

    typedef enum logic [2:0] {
        ST_HALTED,
        ST_RUNNING,
        ST_STEP,
        ST_CPURST,
        ST_MEMACC
    } dbg_state_e;

    // The CPU owns the data RAM whenever it may be executing.
    function automatic logic cpu_owns(input dbg_state_e s);
        return (s == ST_RUNNING) || (s == ST_STEP) || (s == ST_CPURST);
    endfunction

endpackage

// File: rtl/hack_ram_mux.sv
// Data RAM owner select between the CPU core and the debug port.
module hack_ram_mux
    import hack_dbg_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  dbg_state_e        state,
    input  logic              cpu_en,
    input  logic [ADDR_W-1:0] cpu_addressM,
    input  logic [DATA_W-1:0] cpu_outM,
    input  logic              cpu_writeM,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    input  logic              dbg_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we
);

    // CPU path while executing, latched debug registers otherwise.
    always_comb begin
        if (cpu_owns(state)) begin
            ram_addr = cpu_addressM;
            ram_din  = cpu_outM;
            ram_we   = cpu_writeM && cpu_en;
        end else begin
            ram_addr = dbg_addr;
            ram_din  = dbg_data;
            ram_we   = (state == ST_MEMACC) && dbg_wr;
        end
    end

endmodule

// File: rtl/hack_dbg_ctrl.sv
// Debug/run controller: run/halt/step/breakpoint gating and host RAM access.
module hack_dbg_ctrl
    import hack_dbg_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_en,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_addressM,
    input  logic [DATA_W-1:0] cpu_outM,
    input  logic              cpu_writeM,
    output logic [DATA_W-1:0] cpu_inM,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              halted,
    output logic              bp_hit
);

    dbg_state_e        state_q, state_d;
    logic              first_q, first_d;
    logic              bp_hit_q, bp_hit_d;
    logic              bp_en_q, bp_en_d;
    logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic              dbg_wr_q, dbg_wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_pc_q, rsp_pc_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              halted_q, halted_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              accept;
    logic              bp_match;

    // Breakpoint compare and CPU clock enable; a match stalls the CPU in the same cycle.
    always_comb begin
        bp_match = (state_q == ST_RUNNING) && !first_q && bp_en_q && (pc == bp_addr_q);
        cpu_en   = ((state_q == ST_RUNNING) && !bp_match) ||
                   (state_q == ST_STEP) || (state_q == ST_CPURST);
    end

    // Next-state, command decode and response generation.
    always_comb begin
        accept      = cmd_valid && cmd_ready_q;
        state_d     = state_q;
        first_d     = 1'b0;
        bp_hit_d    = bp_hit_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_data_d  = dbg_data_q;
        dbg_wr_d    = dbg_wr_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        rsp_pc_d    = 1'b0;
        case (state_q)
            ST_HALTED: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d     = ST_RUNNING;
                            first_d     = 1'b1;
                            bp_hit_d    = 1'b0;
                            rsp_valid_d = 1'b1;
                        end
                        OP_STEP: begin
                            state_d  = ST_STEP;
                            bp_hit_d = 1'b0;
                        end
                        OP_RESET_CPU: state_d = ST_CPURST;
                        OP_SET_BP: begin
                            bp_addr_d   = cmd_addr;
                            bp_en_d     = cmd_data[0];
                            rsp_valid_d = 1'b1;
                        end
                        OP_MEM_RD, OP_MEM_WR: begin
                            dbg_addr_d = cmd_addr;
                            dbg_data_d = cmd_data;
                            dbg_wr_d   = (cmd_op == OP_MEM_WR);
                            state_d    = ST_MEMACC;
                        end
                        default: rsp_valid_d = 1'b1;
                    endcase
                end
            end
            ST_RUNNING: begin
                // Breakpoint halts first; an accepted command may then override the target.
                if (bp_match) begin
                    state_d  = ST_HALTED;
                    bp_hit_d = 1'b1;
                end
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: rsp_valid_d = 1'b1;
                        OP_HALT: begin
                            state_d     = ST_HALTED;
                            rsp_valid_d = 1'b1;
                        end
                        OP_RESET_CPU: state_d = ST_CPURST;
                        OP_SET_BP: begin
                            bp_addr_d   = cmd_addr;
                            bp_en_d     = cmd_data[0];
                            rsp_valid_d = 1'b1;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_STEP: begin
                state_d     = ST_HALTED;
                rsp_valid_d = 1'b1;
                rsp_pc_d    = 1'b1;
            end
            ST_CPURST: begin
                state_d     = ST_HALTED;
                rsp_valid_d = 1'b1;
            end
            ST_MEMACC: begin
                state_d     = ST_HALTED;
                rsp_valid_d = 1'b1;
                rsp_data_d  = dbg_wr_q ? '0 : ram_dout;
            end
            default: state_d = ST_HALTED;
        endcase
        cmd_ready_d = (state_d == ST_HALTED) || (state_d == ST_RUNNING);
        halted_d    = !cpu_owns(state_d);
        cpu_reset_d = (state_d == ST_CPURST);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALTED;
            first_q     <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= '0;
            dbg_addr_q  <= '0;
            dbg_data_q  <= '0;
            dbg_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_pc_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            halted_q    <= 1'b1;
            cpu_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            bp_hit_q    <= bp_hit_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_data_q  <= dbg_data_d;
            dbg_wr_q    <= dbg_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_pc_q    <= rsp_pc_d;
            cmd_ready_q <= cmd_ready_d;
            halted_q    <= halted_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // STEP reports the pc after the stepped instruction, visible only once the step edge has passed.
    always_comb begin
        rsp_data = rsp_data_q;
        if (rsp_pc_q) begin
            rsp_data             = '0;
            rsp_data[ADDR_W-1:0] = pc;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign halted    = halted_q;
    assign bp_hit    = bp_hit_q;
    assign cpu_reset = cpu_reset_q;
    assign cpu_inM   = ram_dout;

    hack_ram_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram_mux (
        .state       (state_q),
        .cpu_en      (cpu_en),
        .cpu_addressM(cpu_addressM),
        .cpu_outM    (cpu_outM),
        .cpu_writeM  (cpu_writeM),
        .dbg_addr    (dbg_addr_q),
        .dbg_data    (dbg_data_q),
        .dbg_wr      (dbg_wr_q),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we)
    );

endmodule

// File: tb/tb_hack_dbg_ctrl.sv
// Bench for hack_dbg_ctrl: toy CPU + RAM environment, behavioural model, directed and random phases.
module tb_hack_dbg_ctrl;
    import hack_dbg_pkg::*;

    localparam int AW = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] pc = '0;
    logic          cpu_en, cpu_reset;
    logic [AW-1:0] cpu_addressM;
    logic [DW-1:0] cpu_outM;
    logic          cpu_writeM;
    logic [DW-1:0] cpu_inM;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          halted, bp_hit;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int we_cnt  = 0;
    int en_cnt  = 0;

    always #5 clk = ~clk;

    hack_dbg_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .pc(pc), .cpu_en(cpu_en), .cpu_reset(cpu_reset),
        .cpu_addressM(cpu_addressM), .cpu_outM(cpu_outM), .cpu_writeM(cpu_writeM),
        .cpu_inM(cpu_inM), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .halted(halted), .bp_hit(bp_hit)
    );

    // Toy CPU: straight-line program of 32 words; pc 5 stores 0x2345 to RAM[0x10], other odd pcs store too.
    always_comb begin
        if (pc == 15'd5) begin
            cpu_addressM = 15'h0010;
            cpu_outM     = 16'h2345;
            cpu_writeM   = 1'b1;
        end else begin
            cpu_addressM = 15'h0020 + pc;
            cpu_outM     = {1'b0, pc} ^ 16'hA5A5;
            cpu_writeM   = pc[0];
        end
    end

    always @(posedge clk) begin
        if (cpu_en) pc <= cpu_reset ? '0 : ((pc == 15'd31) ? '0 : pc + 15'd1);
    end

    logic [DW-1:0] ram  [0:32767];
    logic [DW-1:0] mmem [0:32767];
    assign ram_dout = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

    always @(negedge clk) begin
        if (ram_we) we_cnt++;
        if (cpu_en) en_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int            due;
        logic          err;
        logic [DW-1:0] data;
        bit            use_pc;
    } rsp_t;
    rsp_t rq[$];

    bit            m_run = 0, m_fresh = 0, m_bp_en = 0, m_bp_hit = 0, m_dbg_wr = 0;
    int            m_busy = 0;  // 0 none, 1 step, 2 cpu reset, 3 host memory access
    logic [AW-1:0] m_bp_addr = '0, m_dbg_addr = '0;
    logic [DW-1:0] m_dbg_data = '0;

    task automatic push_rsp(input logic err, input logic [DW-1:0] data, input bit use_pc);
        rsp_t r;
        r.due = cyc + 1; r.err = err; r.data = data; r.use_pc = use_pc;
        rq.push_back(r);
    endtask

    always @(negedge clk) begin
        bit            bpm, e_en, e_own, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        bpm   = m_run && !m_fresh && m_bp_en && (pc == m_bp_addr);
        e_en  = m_run ? !bpm : (m_busy == 1 || m_busy == 2);
        e_own = m_run || m_busy == 1 || m_busy == 2;
        if (e_own) begin
            e_addr = cpu_addressM; e_din = cpu_outM; e_we = cpu_writeM && e_en;
        end else begin
            e_addr = m_dbg_addr; e_din = m_dbg_data; e_we = (m_busy == 3) && m_dbg_wr;
        end
        chk("cmd_ready", 32'(cmd_ready), 32'(m_busy == 0));
        chk("halted",    32'(halted),    32'(!e_own));
        chk("cpu_en",    32'(cpu_en),    32'(e_en));
        chk("cpu_reset", 32'(cpu_reset), 32'(m_busy == 2));
        chk("bp_hit",    32'(bp_hit),    32'(m_bp_hit));
        chk("ram_we",    32'(ram_we),    32'(e_we));
        chk("ram_addr",  32'(ram_addr),  32'(e_addr));
        chk("ram_din",   32'(ram_din),   32'(e_din));
        chk("cpu_inM",   32'(cpu_inM),   32'(ram_dout));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_err",   32'(rsp_err),   32'(rq[0].err));
            chk("rsp_data",  32'(rsp_data),  rq[0].use_pc ? 32'(pc) : 32'(rq[0].data));
            void'(rq.pop_front());
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        if (e_we) mmem[e_addr] = e_din;

        if (reset) begin
            m_run = 0; m_fresh = 0; m_busy = 0; m_bp_en = 0; m_bp_hit = 0;
            m_bp_addr = '0; m_dbg_addr = '0; m_dbg_data = '0; m_dbg_wr = 0;
            rq.delete();
        end else if (m_busy != 0) begin
            push_rsp(1'b0, (m_busy == 3 && !m_dbg_wr) ? mmem[m_dbg_addr] : '0, m_busy == 1);
            m_busy = 0;
        end else if (m_run) begin
            m_fresh = 0;
            if (bpm) begin m_run = 0; m_bp_hit = 1; end
            if (cmd_valid) begin
                case (cmd_op)
                    OP_NOP:       push_rsp(1'b0, '0, 0);
                    OP_HALT:      begin m_run = 0; push_rsp(1'b0, '0, 0); end
                    OP_RESET_CPU: begin m_run = 0; m_busy = 2; end
                    OP_SET_BP:    begin m_bp_addr = cmd_addr; m_bp_en = cmd_data[0]; push_rsp(1'b0, '0, 0); end
                    default:      push_rsp(1'b1, '0, 0);
                endcase
            end
        end else if (cmd_valid) begin
            case (cmd_op)
                OP_RUN:       begin m_run = 1; m_fresh = 1; m_bp_hit = 0; push_rsp(1'b0, '0, 0); end
                OP_STEP:      begin m_busy = 1; m_bp_hit = 0; end
                OP_RESET_CPU: m_busy = 2;
                OP_SET_BP:    begin m_bp_addr = cmd_addr; m_bp_en = cmd_data[0]; push_rsp(1'b0, '0, 0); end
                OP_MEM_RD, OP_MEM_WR: begin
                    m_dbg_addr = cmd_addr; m_dbg_data = cmd_data;
                    m_dbg_wr = (cmd_op == OP_MEM_WR); m_busy = 3;
                end
                default:      push_rsp(1'b0, '0, 0);
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("send_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d, output logic e);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        chk("rsp_arrives", 32'(rsp_valid), 32'd1);
        d = rsp_data; e = rsp_err;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          e;
        int            c0, n;
        for (int i = 0; i < 32768; i++) begin ram[i] = '0; mmem[i] = '0; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_halted",    32'(halted),    32'd1);
        chk("rst_cpu_en",    32'(cpu_en),    32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        chk("rst_bp_hit",    32'(bp_hit),    32'd0);

        // host write then read back
        c0 = we_cnt;
        send(OP_MEM_WR, 15'h0005, 16'h1234); wait_rsp(d, e);
        chk("wr_err", 32'(e), 32'd0);
        @(negedge clk);
        chk("wr_we_one_cycle", 32'(we_cnt - c0), 32'd1);
        send(OP_MEM_RD, 15'h0005, 16'h0000); wait_rsp(d, e);
        chk("rd_data", 32'(d), 32'h1234);
        chk("rd_err",  32'(e), 32'd0);

        // CPU reset then three single steps
        send(OP_RESET_CPU, '0, '0); wait_rsp(d, e);
        for (int s = 1; s <= 3; s++) begin
            c0 = en_cnt;
            send(OP_STEP, '0, '0); wait_rsp(d, e);
            chk("step_pc", 32'(d), 32'(s));
            chk("step_en_once", 32'(en_cnt - c0), 32'd1);
            chk("step_halted", 32'(halted), 32'd1);
        end

        // breakpoint at 3 from pc 0
        send(OP_RESET_CPU, '0, '0); wait_rsp(d, e);
        send(OP_SET_BP, 15'h0003, 16'h0001); wait_rsp(d, e);
        send(OP_RUN, '0, '0); wait_rsp(d, e);
        n = 0;
        while (!halted && n < 100) begin @(negedge clk); n++; end
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_pc",     32'(pc),     32'd3);
        chk("bp_sticky", 32'(bp_hit), 32'd1);

        // resume past the breakpoint; CPU stores 0x2345 at pc 5
        send(OP_RUN, '0, '0); wait_rsp(d, e);
        chk("resume_bp_clear", 32'(bp_hit), 32'd0);
        repeat (4) @(negedge clk);
        chk("resume_pc", 32'(pc), 32'd7);
        send(OP_MEM_RD, 15'h0000, '0); wait_rsp(d, e);
        chk("run_memrd_err", 32'(e), 32'd1);
        send(OP_HALT, '0, '0); wait_rsp(d, e);
        chk("halt_halted", 32'(halted), 32'd1);
        send(OP_MEM_RD, 15'h0010, '0); wait_rsp(d, e);
        chk("cpu_store", 32'(d), 32'h2345);

        // reset during host memory access
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = OP_MEM_RD; cmd_addr = 15'h0010;
        @(posedge clk); #1;
        cmd_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp",    32'(rsp_valid), 32'd0);
        chk("abort_ready",  32'(cmd_ready), 32'd1);
        chk("abort_addr",   32'(ram_addr),  32'd0);
        chk("abort_halted", 32'(halted),    32'd1);

        // random phase
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_addr  = (cmd_op == OP_SET_BP) ? 15'($urandom_range(0, 31)) : 15'($urandom_range(0, 63));
            cmd_data  = 16'($urandom);
            reset     = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; reset = 1'b0;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hack_dbg_ctrl.md
# hack_dbg_ctrl

Debug/run controller for the Hack CPU core. Sits between a host command port (UART/SPI bridge) and the CPU + data RAM. Gates CPU execution with a clock enable (run, halt, single-step, PC breakpoint) and arbitrates data RAM ownership so the host can read and write memory while the CPU is halted.

## Interface
Parameters:
- ADDR_W, 15, RAM address / PC width
- DATA_W, 16, data / instruction width

Ports (clk rising edge; reset synchronous, active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  opcode: 0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 RESET_CPU, 5 SET_BP, 6 MEM_RD, 7 MEM_WR
- cmd_addr  in  ADDR_W  address (MEM_RD/MEM_WR/SET_BP)
- cmd_data  in  DATA_W  write data; for SET_BP, bit 0 = breakpoint enable
- rsp_valid  out  1  one-cycle response strobe, one per accepted command
- rsp_err  out  1  command illegal in current state; qualified by rsp_valid
- rsp_data  out  DATA_W  read data (MEM_RD), new pc zero-extended (STEP), else 0
- pc  in  ADDR_W  CPU program counter
- cpu_en  out  1  CPU clock enable; one instruction retires per enabled cycle
- cpu_reset  out  1  reset to CPU core
- cpu_addressM  in  ADDR_W  CPU data address
- cpu_outM  in  DATA_W  CPU write data
- cpu_writeM  in  1  CPU write request
- cpu_inM  out  DATA_W  read data to CPU (= ram_dout)
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DATA_W  RAM read data, combinational (asynchronous read)
- halted  out  1  CPU is not executing
- bp_hit  out  1  sticky: last halt caused by breakpoint

## Operation
- States: HALTED, RUNNING, STEP, CPURST, MEMACC. Reset state HALTED.
- Command accepted on cmd_valid && cmd_ready. cmd_ready = 1 in HALTED and RUNNING, 0 in STEP, CPURST, MEMACC.
- HALTED: NOP/HALT -> rsp ok, stay. RUN -> RUNNING, clear bp_hit. STEP -> STEP, clear bp_hit. RESET_CPU -> CPURST. SET_BP -> load bp_addr/bp_en. MEM_RD/MEM_WR -> latch addr/data/op, MEMACC.
- RUNNING: cpu_en = 1. HALT -> HALTED. RESET_CPU -> CPURST. SET_BP/NOP ok. RUN, STEP, MEM_RD, MEM_WR -> rsp_err = 1, no effect.
- Breakpoint: in RUNNING, if bp_en && pc == bp_addr, cpu_en = 0 that same cycle (instruction at bp_addr not executed), set bp_hit, -> HALTED. Compare suppressed on the first RUNNING cycle after RUN so a run resumes from a breakpoint address. Breakpoint alone generates no rsp.
- STEP: cpu_en = 1 for exactly one cycle (no breakpoint check), -> HALTED; rsp carries pc as seen in following cycle.
- CPURST: cpu_reset = 1 and cpu_en = 1 for one cycle, -> HALTED.
- MEMACC: host owns RAM for one cycle: ram_addr = latched addr, ram_we = 1 for MEM_WR only, ram_din = latched data; rsp_data captures ram_dout (MEM_RD) at end of cycle. -> HALTED.
- RAM mux: CPU owns in RUNNING, STEP, CPURST (ram_addr = cpu_addressM, ram_din = cpu_outM, ram_we = cpu_writeM && cpu_en); otherwise debug registers own, ram_we = 0 except MEMACC write.
- Simultaneous: HALT accepted in the same cycle as a breakpoint match -> HALTED, bp_hit = 1, rsp ok. SET_BP in RUNNING takes effect on the next cycle's compare.

## Timing
- Reset values: state HALTED, cmd_ready 1, rsp_valid 0, rsp_err 0, rsp_data 0, cpu_en 0, cpu_reset 0, halted 1, bp_hit 0, bp_en 0, bp_addr 0, debug addr/data 0, so ram_addr 0, ram_we 0.
- Reset mid-operation (any state) aborts it; no rsp is issued for the aborted command.
- Responses registered: command accepted in cycle N -> rsp_valid in cycle N+1 for HALT/RUN/NOP/SET_BP/errors, N+2 for STEP, RESET_CPU, MEM_RD, MEM_WR.
- halted = (state != RUNNING && state != STEP && state != CPURST), registered from state.
- bp_addr compare is full ADDR_W equality; no wrap or masking.

## Structure
- Package hack_dbg_pkg: opcode constants, state enum, ADDR_W/DATA_W defaults.
- One sub-module: hack_ram_mux (combinational owner select between CPU and debug port). FSM, breakpoint compare, and response register stay in hack_dbg_ctrl.

## Test plan
- Reset, then MEM_WR addr 0x0005 data 0x1234, MEM_RD 0x0005 -> rsp_data 0x1234, rsp_err 0; ram_we high exactly one cycle.
- RESET_CPU, 3x STEP -> cpu_en high one cycle each; rsp_data 1, 2, 3 for straight-line code; halted 1 between steps.
- SET_BP 0x0003 en=1, RUN -> cpu_en drops in cycle pc==3, halted 1, bp_hit 1; RUN again -> pc advances past 3, bp_hit cleared.
- While RUNNING, MEM_RD 0x0000 -> rsp_err 1, no RAM ownership change; HALT -> halted 1 next cycle.
- CPU program writes 0x2345 to RAM[0x10] while RUNNING; HALT, MEM_RD 0x10 -> 0x2345.
- Assert reset during MEMACC -> no rsp_valid, all outputs at reset values next cycle.
